// File: rtl/soc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// soc_mem_arbiter
//
// Shares one synchronous RAM between NUM_CH requesting masters. Channel 0 is
// the instruction-fetch port by convention. Further channels can be load/store,
// debug or DMA ports.
//
// Request path
//   A round-robin arbiter issues at most one request per cycle. The grant is
//   combinational, so the winner's request drives the RAM in the same cycle.
//
// Response path
//   A MEM_LAT-deep tag pipeline records which channel issued each access and
//   whether it was a write. Responses therefore come back in issue order,
//   exactly MEM_LAT cycles after the grant. Responses cannot be back-pressured.
//
// Parameters
//   NUM_CH   number of channels, 1..8
//   ADDR_W   address width
//   DATA_W   data width
//   MEM_LAT  RAM read latency in cycles, 1..4 (write acks use the same latency)
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   req_valid_i     per-channel request valid
//   req_ready_o     per-channel grant (one-hot or zero)
//   req_we_i        per-channel write enable (1 = write)
//   req_type_i      per-channel 3-bit access type, flattened
//   req_addr_i      per-channel address, flattened (channel k at k*ADDR_W)
//   req_wdata_i     per-channel write data, flattened
//   rsp_valid_o     one-hot response strobe
//   rsp_rdata_o     read data for the response (0 for write acks)
//   mem_ren_o       RAM read enable
//   mem_wen_o       RAM write enable
//   mem_type_o      RAM access type
//   mem_addr_o      RAM address
//   mem_wdata_o     RAM write data
//   mem_rdata_i     RAM read data, valid MEM_LAT cycles after mem_ren_o
// -----------------------------------------------------------------------------
module soc_mem_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_valid_i,
  output logic [NUM_CH-1:0]        req_ready_o,
  input  logic [NUM_CH-1:0]        req_we_i,
  input  logic [NUM_CH*3-1:0]      req_type_i,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata_i,
  output logic [NUM_CH-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]        rsp_rdata_o,
  output logic                     mem_ren_o,
  output logic                     mem_wen_o,
  output logic [2:0]               mem_type_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_wdata_o,
  input  logic [DATA_W-1:0]        mem_rdata_i
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef struct packed {
    logic              valid;
    logic [NUM_CH-1:0] id;
    logic              is_write;
  } tag_t;

  logic [PTR_W-1:0] rr_ptr;
  logic             granted;
  logic [PTR_W-1:0] grant_id;
  logic             grant_we;
  tag_t             tag_q [MEM_LAT];
  tag_t             tag_out;

  // ---------------------------------------------------------------------------
  // Round-robin grant
  //
  // The search starts at rr_ptr and takes the first valid channel. While rst
  // is high nothing is granted, so the RAM sees no enables.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    granted  = 1'b0;
    grant_id = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      int idx;
      idx = (int'(rr_ptr) + i) % NUM_CH;
      if (!granted && req_valid_i[idx]) begin
        granted  = 1'b1;
        grant_id = PTR_W'(idx);
      end
    end
    if (rst) begin
      granted = 1'b0;
    end
  end

  assign grant_we = req_we_i[grant_id];

  // Issue: the winner's request drives the RAM; every field is zero when idle.
  always_comb begin
    req_ready_o = '0;
    mem_ren_o   = 1'b0;
    mem_wen_o   = 1'b0;
    mem_type_o  = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (granted) begin
      req_ready_o = NUM_CH'(1) << grant_id;
      mem_ren_o   = ~grant_we;
      mem_wen_o   = grant_we;
      mem_addr_o  = req_addr_i[grant_id*ADDR_W +: ADDR_W];
      mem_wdata_o = req_wdata_i[grant_id*DATA_W +: DATA_W];
      // A write carries its type in bits [1:0] only.
      mem_type_o  = req_type_i[grant_id*3 +: 3];
      if (grant_we) begin
        mem_type_o[2] = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin pointer
  //
  // After a grant, the pointer moves to the channel after the winner. It holds
  // when there is no grant, including when a master drops valid unserved.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge.
    if (rst) begin
      rr_ptr <= '0;
    end else if (granted) begin
      rr_ptr <= (grant_id == PTR_W'(NUM_CH - 1)) ? '0 : grant_id + PTR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline
  //
  // Stage 0 captures the current issue, or an invalid tag when nothing issues.
  // The last stage lines up with the RAM read data.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the tag stages are control state, not a data store. Every stage is
    // reset so that accesses in flight at reset never produce a response.
    if (rst) begin
      for (int s = 0; s < MEM_LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0].valid    <= granted;
      tag_q[0].id       <= granted ? req_ready_o : '0;
      tag_q[0].is_write <= granted & grant_we;
      for (int s = 1; s < MEM_LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  assign tag_out = tag_q[MEM_LAT-1];

  // Response: a one-hot strobe for one cycle; read data only for reads.
  always_comb begin
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    if (tag_out.valid) begin
      rsp_valid_o = tag_out.id;
      if (!tag_out.is_write) begin
        rsp_rdata_o = mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_soc_mem_arbiter
//
// Directed bench for soc_mem_arbiter, using two instances:
//   dut    : NUM_CH=4, 32-bit address/data, MEM_LAT=2, with a small RAM model
//   dut_l4 : NUM_CH=2, 16-bit address/data, MEM_LAT=4, used for the
//            reset-while-in-flight case
//
// Inputs change just after the falling edge. Outputs are sampled 1 time unit
// later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_soc_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- main instance: 4 channels, MEM_LAT = 2 ----------------
  logic         rst;
  logic [3:0]   req_valid, req_ready, req_we, rsp_valid;
  logic [11:0]  req_type;
  logic [127:0] req_addr, req_wdata;
  logic [31:0]  rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic         mem_ren, mem_wen;
  logic [2:0]   mem_type;

  soc_mem_arbiter #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_type_i(req_type), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .mem_ren_o(mem_ren), .mem_wen_o(mem_wen), .mem_type_o(mem_type),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // RAM model with 2-cycle read latency. Word index comes from addr[9:2].
  // Each word is preloaded to A000_00xx, except 0x100, which holds DEAD_BEEF.
  logic [31:0] ram [256];
  logic [31:0] rd_pipe [2];
  logic        ram_loaded = 1'b0;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'hA000_0000 | 32'(i);
      ram[64]    <= 32'hDEAD_BEEF;
      ram_loaded <= 1'b1;
    end else if (mem_wen) begin
      ram[mem_addr[9:2]] <= mem_wdata;
    end
    rd_pipe[0] <= mem_ren ? ram[mem_addr[9:2]] : 32'h0;
    rd_pipe[1] <= rd_pipe[0];
  end
  assign mem_rdata = rd_pipe[1];

  // ---------------- second instance: 2 channels, MEM_LAT = 4 ---------------
  logic        b_rst;
  logic [1:0]  b_valid, b_ready, b_rsp_valid;
  logic [1:0]  b_we = 2'b00;
  logic [5:0]  b_type = 6'd0;
  logic [31:0] b_addr = 32'h0020_0010;
  logic [31:0] b_wdata = 32'h0;
  logic [15:0] b_rsp_rdata, b_mem_addr, b_mem_wdata;
  logic [15:0] b_mem_rdata = 16'hBEEF;
  logic        b_mem_ren, b_mem_wen;
  logic [2:0]  b_mem_type;

  soc_mem_arbiter #(.NUM_CH(2), .ADDR_W(16), .DATA_W(16), .MEM_LAT(4)) dut_l4 (
    .clk(clk), .rst(b_rst),
    .req_valid_i(b_valid), .req_ready_o(b_ready), .req_we_i(b_we),
    .req_type_i(b_type), .req_addr_i(b_addr), .req_wdata_i(b_wdata),
    .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rsp_rdata),
    .mem_ren_o(b_mem_ren), .mem_wen_o(b_mem_wen), .mem_type_o(b_mem_type),
    .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata)
  );

  task automatic set_req(input int ch, input logic we, input logic [2:0] ty,
                         input logic [31:0] a, input logic [31:0] d);
    req_we[ch]          = we;
    req_type[ch*3 +: 3] = ty;
    req_addr[ch*32 +: 32]  = a;
    req_wdata[ch*32 +: 32] = d;
  endtask

  // Read data expected for channel k reading address 0x100 + 4k.
  logic [31:0] exp_rd [4];

  initial begin
    exp_rd[0] = 32'hDEAD_BEEF;
    exp_rd[1] = 32'hA000_0041;
    exp_rd[2] = 32'hA000_0042;
    exp_rd[3] = 32'hA000_0043;

    rst = 1'b1; b_rst = 1'b1; b_valid = 2'b00;
    req_valid = 4'h0; req_we = 4'h0; req_type = '0; req_addr = '0; req_wdata = '0;
    for (int k = 0; k < 4; k++) set_req(k, 1'b0, 3'b011, 32'h100 + 32'(4*k), 32'h0);
    req_valid = 4'hF;

    // Reset held 3 cycles with every channel requesting: nothing may issue.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check("rst_ready", 64'(req_ready), 64'h0);
      check("rst_rsp",   64'(rsp_valid), 64'h0);
      check("rst_ren",   64'(mem_ren),   64'h0);
      check("rst_addr",  64'(mem_addr),  64'h0);
    end

    // Release reset. All four channels stay valid for 8 cycles, so grants
    // rotate 0,1,2,3,0,1,2,3 and each response follows 2 cycles later.
    @(negedge clk);
    rst = 1'b0; b_rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) req_valid = 4'h0;
      #1;
      if (c < 8) begin
        check("rr_ready", 64'(req_ready), 64'(4'b0001 << (c % 4)));
        check("rr_addr",  64'(mem_addr),  64'(32'h100 + 32'(4 * (c % 4))));
      end else begin
        check("rr_idle_ready", 64'(req_ready), 64'h0);
      end
      if (c >= 2) begin
        check("rr_rsp",   64'(rsp_valid), 64'(4'b0001 << ((c - 2) % 4)));
        check("rr_rdata", 64'(rsp_rdata), 64'(exp_rd[(c - 2) % 4]));
      end else begin
        check("rr_rsp_early", 64'(rsp_valid), 64'h0);
      end
      @(negedge clk);
    end

    // Single-channel read: ch1 reads 0x100 and gets DEAD_BEEF at T+2.
    set_req(1, 1'b0, 3'b000, 32'h100, 32'h0);
    req_valid = 4'b0010; #1;
    check("rd1_ready", 64'(req_ready), 64'h2);
    check("rd1_ren",   64'(mem_ren),   64'h1);
    check("rd1_addr",  64'(mem_addr),  64'h100);
    @(negedge clk); req_valid = 4'h0; #1;
    check("rd1_rsp_t1",    64'(rsp_valid), 64'h0);
    check("idle_mem_addr", 64'(mem_addr),  64'h0);
    check("idle_mem_ren",  64'(mem_ren),   64'h0);
    @(negedge clk); #1;
    check("rd1_rsp",   64'(rsp_valid), 64'h2);
    check("rd1_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
    @(negedge clk); #1;
    check("rd1_rsp_once", 64'(rsp_valid), 64'h0);

    // Write ack: ch0 writes 0x1234 to 0x40 with type double.
    set_req(0, 1'b1, 3'b011, 32'h40, 32'h1234);
    req_valid = 4'b0001; #1;
    check("wr_ready", 64'(req_ready), 64'h1);
    check("wr_wen",   64'(mem_wen),   64'h1);
    check("wr_ren",   64'(mem_ren),   64'h0);
    check("wr_wdata", 64'(mem_wdata), 64'h1234);
    check("wr_addr",  64'(mem_addr),  64'h40);
    check("wr_type",  64'(mem_type),  64'h3);
    @(negedge clk); req_valid = 4'h0;
    @(negedge clk); #1;
    check("wr_rsp",   64'(rsp_valid), 64'h1);
    check("wr_rdata", 64'(rsp_rdata), 64'h0);

    // A read of the same address returns the written data.
    @(negedge clk);
    set_req(0, 1'b0, 3'b011, 32'h40, 32'h0);
    req_valid = 4'b0001; #1;
    check("rb_ren", 64'(mem_ren), 64'h1);
    @(negedge clk); req_valid = 4'h0;
    @(negedge clk); #1;
    check("rb_rsp",   64'(rsp_valid), 64'h1);
    check("rb_rdata", 64'(rsp_rdata), 64'h1234);

    // Pointer hold: ch2 is granted, then 3 idle cycles. With ch0 and ch3 both
    // requesting, ch3 wins first.
    @(negedge clk);
    set_req(2, 1'b0, 3'b000, 32'h108, 32'h0);
    req_valid = 4'b0100; #1;
    check("ph_ch2", 64'(req_ready), 64'h4);
    @(negedge clk); req_valid = 4'h0;
    repeat (3) @(negedge clk);
    set_req(3, 1'b0, 3'b000, 32'h10C, 32'h0);
    req_valid = 4'b1001; #1;
    check("ph_ch3_first", 64'(req_ready), 64'h8);
    @(negedge clk); req_valid = 4'b0001; #1;
    check("ph_ch0_next", 64'(req_ready), 64'h1);
    @(negedge clk); req_valid = 4'h0;

    // Reset mid-flight on the MEM_LAT=4 instance. Reads issue at T and T+1,
    // and reset is asserted at T+2. No response may appear through T+6.
    b_valid = 2'b11; #1;
    check("mf_grant_t0", 64'(b_ready), 64'h1);
    @(negedge clk); #1;
    check("mf_grant_t1", 64'(b_ready), 64'h2);
    @(negedge clk);
    b_rst = 1'b1; b_valid = 2'b00; #1;
    check("mf_rsp_t2", 64'(b_rsp_valid), 64'h0);
    @(negedge clk);
    b_rst = 1'b0;
    for (int t = 3; t <= 6; t++) begin
      #1;
      check("mf_rsp_after_rst", 64'(b_rsp_valid), 64'h0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
